// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the program counter, captures the
// word returned by instruction memory into an instruction register, and hands it
// to decode over a valid/ready handshake. Handles branch redirect with flush,
// back-pressure stalls and a terminal HALT state.
module fetch_unit #(
  parameter int unsigned AW          = 8,
  parameter int unsigned DW          = 16,
  parameter logic [AW-1:0] RESET_PC  = 8'h00,
  parameter logic [3:0] HALT_OPCODE  = 4'b1111
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] imem_instr,
  output logic [DW-1:0] ir_out,
  output logic [AW-1:0] ir_pc,
  output logic          ir_valid,
  input  logic          ir_ready,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_addr,
  output logic          halted
);

  typedef enum logic {RUN, HALT} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] pc;
  logic          fetch;
  logic          consume;
  logic          is_halt;
  logic          do_redirect;

  // Memory address comes straight from the PC register.
  assign imem_addr = pc;
  assign halted    = (state == HALT);

  // Handshake and fetch qualification.
  always_comb begin
    consume     = ir_valid && ir_ready;
    do_redirect = (state == RUN) && redirect;
    fetch       = (state == RUN) && en && !redirect && (!ir_valid || ir_ready);
    is_halt     = (imem_instr[DW-1 -: 4] == HALT_OPCODE);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Next-state: fetching a HALT word enters HALT; only reset leaves it.
  always_comb begin
    state_nxt = state;
    if (state == RUN && fetch && is_halt) state_nxt = HALT;
  end

  // PC update: redirect has priority; a HALT word freezes the PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    pc <= RESET_PC;
    else if (do_redirect)       pc <= redirect_addr;
    else if (fetch && !is_halt) pc <= pc + AW'(1);
  end

  // Instruction register: flush on redirect, load on fetch, clear when consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_out   <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else if (do_redirect) begin
      ir_valid <= 1'b0;
    end else if (fetch) begin
      ir_out   <= imem_instr;
      ir_pc    <= pc;
      ir_valid <= 1'b1;
    end else if (consume) begin
      ir_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed-vector bench for fetch_unit with a small behavioural
// instruction memory. A second instance with RESET_PC=FE covers PC wrap.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        ir_ready;
  logic        redirect;
  logic [7:0]  redirect_addr;
  logic [7:0]  imem_addr, imem_addr2;
  logic [15:0] imem_instr, imem_instr2;
  logic [15:0] ir_out, ir_out2;
  logic [7:0]  ir_pc, ir_pc2;
  logic        ir_valid, ir_valid2;
  logic        halted, halted2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Program image for the main instance.
  always_comb begin
    case (imem_addr)
      8'd0:    imem_instr = 16'h4100;
      8'd1:    imem_instr = 16'h4202;
      8'd2:    imem_instr = 16'h0321;
      8'd3:    imem_instr = 16'hF000;
      8'd5:    imem_instr = 16'h1132;
      default: imem_instr = 16'h0000;
    endcase
  end

  // Non-halt words everywhere for the wrap instance.
  assign imem_instr2 = {8'h10, imem_addr2};

  fetch_unit #(.AW(8), .DW(16), .RESET_PC(8'h00), .HALT_OPCODE(4'b1111)) dut (
    .clk(clk), .rst(rst), .en(en), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .ir_out(ir_out), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .redirect(redirect), .redirect_addr(redirect_addr), .halted(halted)
  );

  fetch_unit #(.AW(8), .DW(16), .RESET_PC(8'hFE), .HALT_OPCODE(4'b1111)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .imem_addr(imem_addr2), .imem_instr(imem_instr2),
    .ir_out(ir_out2), .ir_pc(ir_pc2), .ir_valid(ir_valid2), .ir_ready(ir_ready),
    .redirect(1'b0), .redirect_addr(8'h00), .halted(halted2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Assert reset mid-cycle, hold across one edge, release just after the next edge.
  task automatic do_reset();
    rst = 1'b1; en = 1'b0; ir_ready = 1'b0; redirect = 1'b0; redirect_addr = 8'h00;
    step();
    rst = 1'b0;
  endtask

  logic [15:0] exp_ir [4] = '{16'h4100, 16'h4202, 16'h0321, 16'hF000};
  logic [7:0]  exp_wrap [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};

  initial begin
    // Reset state
    rst = 1'b1; en = 1'b0; ir_ready = 1'b0; redirect = 1'b0; redirect_addr = 8'h00;
    #2;
    check("rst_addr", imem_addr, 8'h00);
    check("rst_valid", ir_valid, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_ir", ir_out, 16'h0000);
    check("rst_irpc", ir_pc, 8'h00);
    check("rst_addr_wrap", imem_addr2, 8'hFE);
    step();
    rst = 1'b0;

    // Straight-line run to HALT, wrap instance in parallel
    en = 1'b1; ir_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("run_ir", ir_out, exp_ir[i]);
      check("run_pc", ir_pc, i);
      check("run_valid", ir_valid, 1'b1);
      check("run_halted", halted, (i == 3) ? 1'b1 : 1'b0);
      check("wrap_pc", ir_pc2, exp_wrap[i]);
      check("wrap_ir", ir_out2, {8'h10, exp_wrap[i]});
    end
    check("halt_addr", imem_addr, 8'd3);
    step();
    check("halt_valid_clr", ir_valid, 1'b0);
    check("halt_addr_hold", imem_addr, 8'd3);
    redirect = 1'b1; redirect_addr = 8'd5;
    step();
    check("halt_redir_addr", imem_addr, 8'd3);
    check("halt_redir_halted", halted, 1'b1);
    check("halt_redir_valid", ir_valid, 1'b0);

    // Back-pressure
    do_reset();
    en = 1'b1; ir_ready = 1'b1;
    step();
    check("bp_ir0", ir_out, 16'h4100);
    step();
    check("bp_ir1", ir_out, 16'h4202);
    ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_stall_ir", ir_out, 16'h4202);
      check("bp_stall_pc", ir_pc, 8'd1);
      check("bp_stall_addr", imem_addr, 8'd2);
      check("bp_stall_valid", ir_valid, 1'b1);
    end
    ir_ready = 1'b1;
    step();
    check("bp_rel_ir", ir_out, 16'h0321);
    check("bp_rel_pc", ir_pc, 8'd2);
    en = 1'b0;
    step();
    check("en0_valid", ir_valid, 1'b0);
    check("en0_addr", imem_addr, 8'd3);
    check("en0_halted", halted, 1'b0);

    // Redirect flush and one-bubble penalty
    do_reset();
    en = 1'b1; ir_ready = 1'b1;
    step();
    step();
    check("rd_ir_pre", ir_out, 16'h4202);
    redirect = 1'b1; redirect_addr = 8'd5;
    step();
    check("rd_flush_valid", ir_valid, 1'b0);
    check("rd_flush_addr", imem_addr, 8'd5);
    redirect = 1'b0;
    step();
    check("rd_tgt_ir", ir_out, 16'h1132);
    check("rd_tgt_pc", ir_pc, 8'd5);
    check("rd_tgt_addr", imem_addr, 8'd6);
    check("rd_tgt_valid", ir_valid, 1'b1);

    // Redirect while HALT word is presented: HALT discarded
    do_reset();
    en = 1'b1; ir_ready = 1'b1;
    step(); step(); step();
    check("rdh_pre_addr", imem_addr, 8'd3);
    redirect = 1'b1; redirect_addr = 8'd0;
    step();
    check("rdh_halted", halted, 1'b0);
    check("rdh_valid", ir_valid, 1'b0);
    check("rdh_addr", imem_addr, 8'd0);
    redirect = 1'b0;
    step();
    check("rdh_next_ir", ir_out, 16'h4100);
    check("rdh_next_halted", halted, 1'b0);

    // Async reset mid-stall
    do_reset();
    en = 1'b1; ir_ready = 1'b1;
    step(); step();
    ir_ready = 1'b0;
    step();
    check("ar_pre_valid", ir_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid", ir_valid, 1'b0);
    check("ar_halted", halted, 1'b0);
    check("ar_ir", ir_out, 16'h0000);
    check("ar_addr", imem_addr, 8'h00);
    step();
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 16-bit processor. It owns the 8-bit program counter and drives the address port of the instruction memory, which answers combinationally within the same cycle. It captures the returned word into an instruction register and hands it to decode over a valid/ready handshake. It also handles branch redirects with flush, back-pressure stalls, and a terminal HALT state.

## Interface
- `AW`, 8: program-counter and instruction-memory address width.
- `DW`, 16: instruction width.
- `RESET_PC`, 8'h00: PC value after reset.
- `HALT_OPCODE`, 4'b1111: opcode in `instr[15:12]` that stops fetching.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  fetch enable; low pauses fetching without losing state.
- `imem_addr`  out  AW  address to instruction memory; equals the PC register.
- `imem_instr`  in  DW  word returned combinationally for `imem_addr`.
- `ir_out`  out  DW  latched instruction for decode.
- `ir_pc`  out  AW  address from which `ir_out` was fetched.
- `ir_valid`  out  1  `ir_out`/`ir_pc` hold an instruction not yet consumed.
- `ir_ready`  in  1  decode accepts `ir_out` this cycle.
- `redirect`  in  1  execute-stage branch/jump taken.
- `redirect_addr`  in  AW  branch target.
- `halted`  out  1  HALT state reached.

## Operation
- State machine with two states, RUN and HALT. Only `rst` leaves HALT.
- `imem_addr` is driven directly from the PC register, never from combinational logic.
- Consume: `ir_valid && ir_ready` in a cycle means decode has taken the current IR.
- Fetch condition: state RUN, `en`=1, `redirect`=0, and either `ir_valid`=0 or `ir_ready`=1.
- On a fetch:
  - `ir_out` <= `imem_instr`, `ir_pc` <= PC, `ir_valid` <= 1.
  - If `imem_instr[15:12]` == `HALT_OPCODE`: PC holds and the state goes to HALT. The HALT word itself is still delivered to decode.
  - Otherwise PC <= PC+1, modulo 2^AW (255 wraps to 0, no flag).
- Stall: `ir_valid`=1 with `ir_ready`=0 holds PC, `ir_out`, `ir_pc` and `ir_valid` unchanged.
- Not fetching, but IR consumed: `ir_valid` <= 0.
- `en`=0 in RUN: no fetch. PC holds. A pending IR may still be consumed, which clears `ir_valid`.
- Redirect (RUN only, highest priority):
  - PC <= `redirect_addr` and `ir_valid` <= 0, which flushes the wrong-path IR even if `ir_ready`=1.
  - No fetch happens that cycle, so a HALT word on `imem_instr` that cycle is discarded.
  - The first fetch from the target happens the next cycle, if the fetch condition holds.
- `redirect` in HALT is ignored.
- HALT state: no fetches. The pending IR (the HALT word) stays valid until consumed, then `ir_valid`=0 permanently. `halted`=1.
- Reset mid-operation: all state returns to reset values immediately, regardless of the clock. The in-flight IR is lost.

## Timing
- Reset values: PC = `imem_addr` = `RESET_PC`; `ir_out`=0; `ir_pc`=0; `ir_valid`=0; `halted`=0; state RUN.
- Fetch latency is one cycle: with `en`=1 at edge k, `ir_out` = mem[PC] and `ir_valid`=1 after edge k.
- Sustained throughput is 1 instruction/cycle while `ir_ready`=1 and `en`=1.
- Redirect penalty is one bubble: redirect sampled at edge k; target word in IR after edge k+1.
- `halted` rises at the same edge that latches the HALT word.
- `imem_instr` is sampled only at a fetch edge and must settle within the cycle `imem_addr` is stable.
- Simultaneous redirect and `ir_ready` at the same edge: the flush wins and the IR counts as dropped, not delivered.

## Test plan
Memory image: 0:4100, 1:4202, 2:0321, 3:F000, 5:1132.
- Straight-line run: reset, `en`=1, `ir_ready`=1 → IR sequence 4100/0, 4202/1, 0321/2, F000/3 on consecutive cycles; `halted`=1 with F000; `ir_valid`=0 the next cycle; `imem_addr` stays 3.
- Back-pressure: hold `ir_ready`=0 for 3 cycles after 4202 is latched → `ir_out`=4202, `ir_pc`=1, `imem_addr`=2 constant. Release → 0321 the next cycle, with no skip or duplicate.
- Redirect: `redirect`=1, `redirect_addr`=5 while IR=4202 → next cycle `ir_valid`=0; following cycle IR=1132, `ir_pc`=5, `imem_addr`=6.
- Wrap: `RESET_PC`=8'hFE with non-halt words → `ir_pc` runs FE, FF, 00, 01.
- Redirect while F000 is presented at address 3 → HALT not entered, `halted`=0, F000 never valid; `redirect` in HALT state → ignored.
- Async reset mid-stall (`ir_valid`=1) between clock edges → `ir_valid`, `halted`, `ir_out` go to 0 and `imem_addr`=`RESET_PC` immediately.
